// File: rtl/gf180mcu_fd_io__pwrseq_pkg.sv
// Shared types and helpers for the GF180MCU IO-ring supply sequencer.
// Holds the state encoding, counter sizing helpers and legal parameter ranges.
package gf180mcu_fd_io__pwrseq_pkg;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    DEBOUNCE = 3'd1,
    SEG_ON   = 3'd2,
    RELEASE  = 3'd3,
    RUN      = 3'd4
  } pwrseq_state_e;

  localparam int DEB_CYCLES_MIN  = 1;
  localparam int DEB_CYCLES_MAX  = 4095;
  localparam int STEP_CYCLES_MIN = 1;
  localparam int STEP_CYCLES_MAX = 4095;
  localparam int NSEG_MIN        = 1;
  localparam int NSEG_MAX        = 16;

  // Bits needed to hold values 0..max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_io__sync2.sv
// Two-flop synchronizer for an asynchronous supply-good flag.
// Both stages clear on synchronous reset so a fresh reset always reads "not good".
module gf180mcu_fd_io__sync2 (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= 1'b0;
      q_reg    <= 1'b0;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/gf180mcu_fd_io__pwrseq_ctl.sv
// Supply-sequencing controller: debounce DVDD/VDD good, stage pad segments, release isolation, free PORB.
// Optional brownout tracking is enabled with `define GF180MCU_FD_IO__PWRSEQ_BROWNOUT_EN.
module gf180mcu_fd_io__pwrseq_ctl
  import gf180mcu_fd_io__pwrseq_pkg::*;
#(
  parameter int DEB_CYCLES  = 64,
  parameter int STEP_CYCLES = 16,
  parameter int NSEG        = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            DVDD_OK,
  input  logic            VDD_OK,
  output logic [NSEG-1:0] SEG_EN,
  output logic            IO_REL,
  output logic            PORB,
  output logic            BUSY,
  output logic            FAULT
);

`ifdef GF180MCU_FD_IO__PWRSEQ_BROWNOUT_EN
  // After a brownout the debounce window doubles, so the counter must reach twice as far.
  localparam int DEB_SPAN = 2 * DEB_CYCLES;
`else
  localparam int DEB_SPAN = DEB_CYCLES;
`endif

  localparam int CW = cnt_width(max2(DEB_SPAN, STEP_CYCLES));
  localparam int IW = cnt_width(NSEG);

  localparam logic [CW-1:0] STEP_LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'((DEB_CYCLES >= 2) ? DEB_CYCLES - 2 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NSEG - 1);
  localparam bit            DEB_IS_ONE = (DEB_CYCLES == 1);

  if (DEB_CYCLES < DEB_CYCLES_MIN || DEB_CYCLES > DEB_CYCLES_MAX) begin : g_bad_deb
    $error("DEB_CYCLES out of range");
  end
  if (STEP_CYCLES < STEP_CYCLES_MIN || STEP_CYCLES > STEP_CYCLES_MAX) begin : g_bad_step
    $error("STEP_CYCLES out of range");
  end
  if (NSEG < NSEG_MIN || NSEG > NSEG_MAX) begin : g_bad_nseg
    $error("NSEG out of range");
  end

  // Bit 0 is DVDD_OK, bit 1 is VDD_OK; each gets its own synchronizer.
  logic [1:0] ok_raw;
  logic [1:0] ok_sync;
  logic       good;

  assign ok_raw = {VDD_OK, DVDD_OK};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    gf180mcu_fd_io__sync2 u_sync (
      .clk  (CLK),
      .srst (RST),
      .d    (ok_raw[gi]),
      .q    (ok_sync[gi])
    );
  end

  assign good = &ok_sync;

  pwrseq_state_e   state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [IW-1:0]   idx_reg;
  logic [NSEG-1:0] seg_en_reg;
  logic            io_rel_reg;
  logic            porb_reg;
  logic            busy_reg;
  logic            fault_reg;

  logic [CW-1:0]   deb_last;
  logic            deb_single;
  logic            fault_next;
  logic            step_done;

`ifdef GF180MCU_FD_IO__PWRSEQ_BROWNOUT_EN
  localparam logic [CW-1:0] DEB2_LAST = CW'(2 * DEB_CYCLES - 2);

  assign deb_last   = fault_reg ? DEB2_LAST : DEB_LAST;
  assign deb_single = DEB_IS_ONE && !fault_reg;
  assign fault_next = fault_reg | ((state_reg == RUN) & ~good);
`else
  assign deb_last   = DEB_LAST;
  assign deb_single = DEB_IS_ONE;
  assign fault_next = 1'b0;
`endif

  assign step_done = (cnt_reg == STEP_LAST);

  // Thermometer mask with the lowest n bits set.
  function automatic logic [NSEG-1:0] thermo(input int n);
    logic [NSEG-1:0] r;
    for (int i = 0; i < NSEG; i++) begin
      r[i] = (i < n);
    end
    return r;
  endfunction

  // The OFF->DEBOUNCE edge already counts as the first good cycle, which is why
  // DEBOUNCE exits at DEB_CYCLES-2 and a one-cycle debounce skips DEBOUNCE entirely.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= OFF;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      seg_en_reg <= '0;
      io_rel_reg <= 1'b0;
      porb_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      fault_reg  <= 1'b0;
    end else begin
      fault_reg <= fault_next;
      if (!good) begin
        state_reg  <= OFF;
        cnt_reg    <= '0;
        idx_reg    <= '0;
        seg_en_reg <= '0;
        io_rel_reg <= 1'b0;
        porb_reg   <= 1'b0;
        busy_reg   <= 1'b0;
      end else begin
        case (state_reg)
          OFF: begin
            busy_reg <= 1'b1;
            cnt_reg  <= '0;
            idx_reg  <= '0;
            if (deb_single) begin
              state_reg  <= SEG_ON;
              seg_en_reg <= thermo(1);
            end else begin
              state_reg <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (cnt_reg == deb_last) begin
              state_reg  <= SEG_ON;
              seg_en_reg <= thermo(1);
              cnt_reg    <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          SEG_ON: begin
            if (step_done) begin
              cnt_reg <= '0;
              if (idx_reg == IDX_LAST) begin
                state_reg  <= RELEASE;
                io_rel_reg <= 1'b1;
              end else begin
                idx_reg    <= idx_reg + 1'b1;
                seg_en_reg <= thermo(int'(idx_reg) + 2);
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          RELEASE: begin
            if (step_done) begin
              state_reg <= RUN;
              porb_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          RUN: begin
            state_reg <= RUN;
          end
          default: begin
            state_reg <= OFF;
          end
        endcase
      end
    end
  end

  assign SEG_EN = seg_en_reg;
  assign IO_REL = io_rel_reg;
  assign PORB   = porb_reg;
  assign BUSY   = busy_reg;
  assign FAULT  = fault_reg;

endmodule

// File: tb/tb_gf180mcu_fd_io__pwrseq_ctl.sv
// Self-checking bench for gf180mcu_fd_io__pwrseq_ctl with DEB_CYCLES=4, STEP_CYCLES=2, NSEG=3.
// A run-length model predicts every output each cycle; directed literals pin key edges.
module tb_gf180mcu_fd_io__pwrseq_ctl;

  localparam int DEB = 4;
  localparam int STP = 2;
  localparam int NS  = 3;

`ifdef GF180MCU_FD_IO__PWRSEQ_BROWNOUT_EN
  localparam bit BROWN = 1'b1;
`else
  localparam bit BROWN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          DVDD_OK = 1'b0;
  logic          VDD_OK = 1'b0;
  logic [NS-1:0] SEG_EN;
  logic          IO_REL;
  logic          PORB;
  logic          BUSY;
  logic          FAULT;

  int n_cmp = 0;
  int n_bad = 0;

  gf180mcu_fd_io__pwrseq_ctl #(
    .DEB_CYCLES  (DEB),
    .STEP_CYCLES (STP),
    .NSEG        (NS)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .DVDD_OK (DVDD_OK),
    .VDD_OK  (VDD_OK),
    .SEG_EN  (SEG_EN),
    .IO_REL  (IO_REL),
    .PORB    (PORB),
    .BUSY    (BUSY),
    .FAULT   (FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: synced good is the input two edges late; outputs are a pure function of
  // the number of consecutive edges that have seen synced good high.
  bit            s1d, s2d, s1v, s2v;
  int            run;
  bit            m_fault;
  logic [NS-1:0] m_seg;
  bit            m_rel, m_porb, m_busy;
  bit            chk_en = 1'b0;

  always @(posedge CLK) begin
    int d;
    int nseg;
    if (RST) begin
      s1d = 0; s2d = 0; s1v = 0; s2v = 0;
      run = 0;
      m_fault = 0;
    end else begin
      if (!(s2d && s2v)) begin
        if (m_porb && BROWN) m_fault = 1;
        run = 0;
      end else begin
        run++;
      end
      s2d = s1d; s1d = DVDD_OK;
      s2v = s1v; s1v = VDD_OK;
    end
    d = m_fault ? 2 * DEB : DEB;
    nseg = (run < d) ? 0 : ((run - d) / STP + 1);
    if (nseg > NS) nseg = NS;
    m_seg  = NS'((1 << nseg) - 1);
    m_rel  = (run >= d + NS * STP);
    m_porb = (run >= d + (NS + 1) * STP);
    m_busy = (run >= 1) && !m_porb;
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("cyc_seg_en", SEG_EN, m_seg);
      check("cyc_io_rel", IO_REL, m_rel);
      check("cyc_porb",   PORB,   m_porb);
      check("cyc_busy",   BUSY,   m_busy);
      check("cyc_fault",  FAULT,  m_fault);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic restart();
    DVDD_OK = 0;
    VDD_OK  = 0;
    RST     = 1;
    step(2);
    RST = 0;
    step(1);
    check("restart_fault", FAULT, 0);
    check("restart_seg", SEG_EN, 0);
  endtask

  initial begin
    int dr;
    dr = BROWN ? 2 * DEB : DEB;

    // Reset state
    RST = 1;
    step(3);
    chk_en = 1;
    check("rst_seg", SEG_EN, 0);
    check("rst_io_rel", IO_REL, 0);
    check("rst_porb", PORB, 0);
    check("rst_busy", BUSY, 0);
    check("rst_fault", FAULT, 0);
    $display("txn reset: outputs idle");

    // Full power-up; T is the second edge after inputs rise
    RST = 0; DVDD_OK = 1; VDD_OK = 1;
    step(5);
    check("up_seg_pre", SEG_EN, 3'b000);
    check("up_busy", BUSY, 1);
    step(1);
    check("up_seg0", SEG_EN, 3'b001);
    check("model_seg0", m_seg, 3'b001);
    step(2);
    check("up_seg1", SEG_EN, 3'b011);
    step(2);
    check("up_seg2", SEG_EN, 3'b111);
    check("up_rel_pre", IO_REL, 0);
    step(2);
    check("up_rel", IO_REL, 1);
    check("up_porb_pre", PORB, 0);
    step(1);
    check("up_busy_pre", BUSY, 1);
    step(1);
    check("up_porb", PORB, 1);
    check("up_busy_end", BUSY, 0);
    check("model_porb", m_porb, 1);
    $display("txn power-up: SEG_EN=%b IO_REL=%b PORB=%b", SEG_EN, IO_REL, PORB);

    // VDD loss in RUN: outputs clear on the third edge
    VDD_OK = 0;
    step(2);
    check("bo_porb_hold", PORB, 1);
    step(1);
    check("bo_seg", SEG_EN, 0);
    check("bo_rel", IO_REL, 0);
    check("bo_porb", PORB, 0);
    check("bo_fault", FAULT, BROWN);
    VDD_OK = 1;
    step(dr + 1);
    check("bo_redeb_pre", SEG_EN, 0);
    step(1);
    check("bo_redeb_seg0", SEG_EN, 3'b001);
    step(20);
    $display("txn brownout: FAULT=%b redebounce=%0d", FAULT, dr);

    // One-cycle DVDD dropout during DEBOUNCE
    restart();
    DVDD_OK = 1; VDD_OK = 1;
    step(3);
    DVDD_OK = 0;
    step(1);
    DVDD_OK = 1;
    step(2);
    check("drop_busy_off", BUSY, 0);
    step(3);
    check("drop_seg_pre", SEG_EN, 0);
    step(1);
    check("drop_seg0", SEG_EN, 3'b001);
    step(16);
    $display("txn dropout: restarted, PORB=%b", PORB);

    // RST while SEG_EN=011
    restart();
    DVDD_OK = 1; VDD_OK = 1;
    step(8);
    check("rst_mid_seg", SEG_EN, 3'b011);
    RST = 1;
    step(1);
    check("rst_mid_seg0", SEG_EN, 0);
    check("rst_mid_busy", BUSY, 0);
    RST = 0;
    step(14);
    check("rst_mid_porb", PORB, 1);
    $display("txn mid-reset: resequenced, PORB=%b", PORB);

    // Loss coinciding with the step into RELEASE
    restart();
    DVDD_OK = 1; VDD_OK = 1;
    step(9);
    VDD_OK = 0;
    step(1);
    check("race_seg_full", SEG_EN, 3'b111);
    step(1);
    check("race_rel_pre", IO_REL, 0);
    step(1);
    check("race_rel", IO_REL, 0);
    check("race_seg", SEG_EN, 0);
    check("race_fault", FAULT, 0);
    $display("txn loss-vs-release: IO_REL=%b SEG_EN=%b", IO_REL, SEG_EN);
    step(4);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
